// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Data wins by default; a waiting fetch is forced in after MAX_DM_BURST data grants.
module mem_port_arbiter #(
    parameter int MAX_DM_BURST = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    output logic        if_stall,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_valid,
    output logic        dm_stall,
    output logic        mem_cs,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int CW = $clog2(MAX_DM_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DM_BURST);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] dm_cnt_q, dm_cnt_d;
    logic          drop_q, drop_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;

    logic if_ok;
    logic grant_dm;
    logic grant_if;
    logic live;

    // A fetch paired with a flush is stale and must not take the port.
    always_comb begin
        if_ok    = if_req && !if_flush;
        grant_dm = 1'b0;
        grant_if = 1'b0;
        if (state_q == IDLE) begin
            if (dm_req && !(if_ok && dm_cnt_q == CNT_MAX)) begin
                grant_dm = 1'b1;
            end else if (if_ok) begin
                grant_if = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        dm_cnt_d = dm_cnt_q;
        drop_d   = drop_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (grant_dm) begin
                    state_d = DM_BUSY;
                    addr_d  = dm_addr;
                    we_d    = dm_we;
                    wdata_d = dm_wdata;
                    if (!if_req) begin
                        dm_cnt_d = '0;
                    end else if (dm_cnt_q != CNT_MAX) begin
                        dm_cnt_d = dm_cnt_q + 1'b1;
                    end
                end else if (grant_if) begin
                    state_d  = IF_BUSY;
                    addr_d   = if_addr;
                    we_d     = 1'b0;
                    wdata_d  = '0;
                    dm_cnt_d = '0;
                end
            end
            IF_BUSY: begin
                if (mem_ack) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                end else if (if_flush) begin
                    drop_d = 1'b1;
                end
            end
            DM_BUSY: begin
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            dm_cnt_q <= '0;
            drop_q   <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            dm_cnt_q <= dm_cnt_d;
            drop_q   <= drop_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    // Reset abandons a transaction immediately, so nothing leaks while RST is high.
    assign live      = !RST;
    assign mem_cs    = live && (state_q != IDLE);
    assign mem_we    = mem_cs && we_q;
    assign mem_addr  = live ? addr_q : '0;
    assign mem_wdata = live ? wdata_q : '0;

    assign if_valid = live && (state_q == IF_BUSY) && mem_ack
                      && !drop_q && !if_flush;
    assign dm_valid = live && (state_q == DM_BUSY) && mem_ack;
    assign if_rdata = if_valid ? mem_rdata : '0;
    assign dm_rdata = dm_valid ? mem_rdata : '0;
    assign if_stall = if_req && !if_valid;
    assign dm_stall = dm_req && !dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change 1ns after each rising
// edge, outputs are checked on the falling edge of the same cycle.
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        dm_stall;
    logic        mem_cs;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int vectors = 0;
    int errs    = 0;

    mem_port_arbiter #(.MAX_DM_BURST(2)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .if_stall  (if_stall),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_valid  (dm_valid),
        .dm_stall  (dm_stall),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        @(negedge CLK);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_cs"}, 32'(mem_cs), 32'd0);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_ifv"}, 32'(if_valid), 32'd0);
        chk({tag, "_dmv"}, 32'(dm_valid), 32'd0);
        chk({tag, "_ifd"}, if_rdata, 32'd0);
        chk({tag, "_dmd"}, dm_rdata, 32'd0);
    endtask

    logic [5:0] order;

    initial begin
        RST = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        mem_rdata = '0; mem_ack = 1'b0;

        // reset and the IDLE cycle after it
        tick(); settle();
        chk_quiet("rst");
        chk("rst_addr", mem_addr, 32'd0);
        tick(); RST = 1'b0; settle();
        chk_quiet("post_rst");
        chk("post_rst_addr", mem_addr, 32'd0);
        chk("post_rst_wd", mem_wdata, 32'd0);
        chk("post_rst_stall", 32'({if_stall, dm_stall}), 32'd0);
        chk("post_rst_cnt", 32'(dut.dm_cnt_q), 32'd0);

        // basic fetch, ack two cycles after the request
        tick(); if_req = 1'b1; if_addr = 32'h100; settle();
        chk("f0_cs", 32'(mem_cs), 32'd0);
        chk("f0_stall", 32'(if_stall), 32'd1);
        tick(); settle();
        chk("f1_cs", 32'(mem_cs), 32'd1);
        chk("f1_addr", mem_addr, 32'h100);
        chk("f1_we", 32'(mem_we), 32'd0);
        chk("f1_valid", 32'(if_valid), 32'd0);
        chk("f1_stall", 32'(if_stall), 32'd1);
        tick(); mem_ack = 1'b1; mem_rdata = 32'h13; settle();
        chk("f2_cs", 32'(mem_cs), 32'd1);
        chk("f2_valid", 32'(if_valid), 32'd1);
        chk("f2_rdata", if_rdata, 32'h13);
        chk("f2_stall", 32'(if_stall), 32'd0);
        chk("f2_dmv", 32'(dm_valid), 32'd0);
        tick(); if_req = 1'b0; mem_ack = 1'b0; mem_rdata = '0; settle();
        chk_quiet("f3");

        // stray ack while idle
        tick(); mem_ack = 1'b1; mem_rdata = 32'hAA; settle();
        chk_quiet("ia0");
        tick(); settle();
        chk_quiet("ia1");
        chk("ia1_state", 32'(dut.state_q), 32'd0);
        mem_ack = 1'b0; mem_rdata = '0;

        // both held: expect D, D, I, D, D, I (1 = data grant)
        order = 6'b011011;
        tick();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000;
        if_req = 1'b1; if_addr = 32'h400;
        for (int i = 0; i < 6; i++) begin
            settle();
            chk($sformatf("arb%0d_idle", i), 32'(mem_cs), 32'd0);
            tick(); settle();
            chk($sformatf("arb%0d_cs", i), 32'(mem_cs), 32'd1);
            chk($sformatf("arb%0d_addr", i), mem_addr,
                order[i] ? 32'h2000 : 32'h400);
            tick(); mem_ack = 1'b1; mem_rdata = 32'h50 + 32'(i); settle();
            chk($sformatf("arb%0d_dmv", i), 32'(dm_valid), 32'(order[i]));
            chk($sformatf("arb%0d_ifv", i), 32'(if_valid), 32'(!order[i]));
            chk($sformatf("arb%0d_dat", i),
                order[i] ? dm_rdata : if_rdata, 32'h50 + 32'(i));
            tick(); mem_ack = 1'b0; mem_rdata = '0;
        end
        dm_req = 1'b0; if_req = 1'b0; settle();
        chk_quiet("arb_end");

        // flush while a fetch is outstanding
        tick(); if_req = 1'b1; if_addr = 32'h200; settle();
        tick(); if_flush = 1'b1; settle();
        chk("fl1_addr", mem_addr, 32'h200);
        chk("fl1_valid", 32'(if_valid), 32'd0);
        tick(); if_flush = 1'b0; if_addr = 32'h300; settle();
        chk("fl2_cs", 32'(mem_cs), 32'd1);
        chk("fl2_addr", mem_addr, 32'h200);
        tick(); mem_ack = 1'b1; mem_rdata = 32'h77; settle();
        chk("fl3_cs", 32'(mem_cs), 32'd1);
        chk("fl3_valid", 32'(if_valid), 32'd0);
        chk("fl3_rdata", if_rdata, 32'd0);
        tick(); mem_ack = 1'b0; mem_rdata = '0; settle();
        chk("fl4_cs", 32'(mem_cs), 32'd0);
        tick(); settle();
        chk("fl5_cs", 32'(mem_cs), 32'd1);
        chk("fl5_addr", mem_addr, 32'h300);
        tick(); mem_ack = 1'b1; mem_rdata = 32'h99; settle();
        chk("fl6_valid", 32'(if_valid), 32'd1);
        chk("fl6_rdata", if_rdata, 32'h99);
        tick(); if_req = 1'b0; mem_ack = 1'b0; mem_rdata = '0; settle();
        chk_quiet("fl7");

        // store
        tick();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h1000;
        dm_wdata = 32'hDEADBEEF; settle();
        chk("st0_cs", 32'(mem_cs), 32'd0);
        tick(); settle();
        chk("st1_cs", 32'(mem_cs), 32'd1);
        chk("st1_we", 32'(mem_we), 32'd1);
        chk("st1_addr", mem_addr, 32'h1000);
        chk("st1_wd", mem_wdata, 32'hDEADBEEF);
        chk("st1_dmv", 32'(dm_valid), 32'd0);
        chk("st1_stall", 32'(dm_stall), 32'd1);
        tick(); mem_ack = 1'b1; mem_rdata = 32'h5A5A; settle();
        chk("st2_we", 32'(mem_we), 32'd1);
        chk("st2_wd", mem_wdata, 32'hDEADBEEF);
        chk("st2_dmv", 32'(dm_valid), 32'd1);
        chk("st2_rdata", dm_rdata, 32'h5A5A);
        chk("st2_stall", 32'(dm_stall), 32'd0);
        tick(); dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
        mem_rdata = '0; settle();
        chk_quiet("st3");

        // reset during a data transaction, ack arrives afterwards
        tick();
        dm_req = 1'b1; dm_addr = 32'h3000; dm_wdata = '0;
        if_req = 1'b1; if_addr = 32'h500; settle();
        tick(); settle();
        chk("rb1_cs", 32'(mem_cs), 32'd1);
        chk("rb1_cnt", 32'(dut.dm_cnt_q), 32'd1);
        tick(); RST = 1'b1; settle();
        chk("rb2_cs", 32'(mem_cs), 32'd0);
        chk("rb2_dmv", 32'(dm_valid), 32'd0);
        tick(); RST = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h66;
        dm_req = 1'b0; if_req = 1'b0; settle();
        chk_quiet("rb3");
        chk("rb3_state", 32'(dut.state_q), 32'd0);
        chk("rb3_cnt", 32'(dut.dm_cnt_q), 32'd0);
        chk("rb3_addr", mem_addr, 32'd0);
        tick(); mem_ack = 1'b0; mem_rdata = '0; settle();
        chk_quiet("rb4");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
